paddle_motion_ctrl: RTL and testbench
=====================================

// Module: paddle_motion_ctrl
// PURPOSE
//  Parametrised multi-paddle position controller. Replaces the single hard-coded button->position block.
//  Synchronises per-paddle up/down buttons and generates its own motion tick from board_clk.
//  Moves each paddle with saturating clamps and hold-to-accelerate. Feeds packed positions to VGA draw logic and the SSD.
// PARAMETERS
//  NUM_P      2        number of paddles (channels)
//  POS_W      10       position width, bits
//  POS_MIN    10       lowest legal position (clamp)
//  POS_MAX    469      highest legal position (clamp)
//  POS_INIT   240      position after reset / recentre
//  STEP       2        slow step per tick
//  FAST_STEP  6        fast step per tick
//  HOLD_TICKS 16       consecutive same-direction move ticks before fast mode
//  TICK_DIV   2097152  board_clk cycles per motion tick (~24 Hz at 50 MHz)
//  Legal: POS_MIN<=POS_INIT<=POS_MAX<2**POS_W; 1<=STEP<=FAST_STEP; TICK_DIV>=2; HOLD_TICKS>=1
// PORTS
//  board_clk  in   1            system clock
//  reset      in   1            reset, asynchronous, active-high
//  enable     in   1            1 = motion ticks honoured
//  btn_up     in   NUM_P        raw async buttons, bit i = paddle i up (decrease pos)
//  btn_dn     in   NUM_P        raw async buttons, bit i = paddle i down (increase pos)
//  recentre   in   NUM_P        sync 1-cycle request; paddle i to POS_INIT
//  pos        out  NUM_P*POS_W  packed positions; paddle i at [i*POS_W +: POS_W]
//  at_min     out  NUM_P        pos[i]==POS_MIN
//  at_max     out  NUM_P        pos[i]==POS_MAX
//  moved      out  NUM_P        1-cycle pulse: pos[i] changed on last tick
//  tick       out  1            motion strobe, 1 cycle every TICK_DIV cycles
// BEHAVIOUR
//  Reset (async, all regs): pos=POS_INIT, FSM=IDLE, hold_cnt=0, tick_cnt=0; tick=0, moved=0, sync FFs=0.
//  at_min/at_max decode registered pos, so they are valid at reset.
//  Sync: btn_up/btn_dn pass a 2-FF synchroniser -> up_s/dn_s, 2-cycle latency.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and wraps; tick=1 registered when tick_cnt==TICK_DIV-1. Runs regardless of enable.
//  Direction per paddle: up_s&~dn_s = UP; dn_s&~up_s = DN; both or neither = NONE.
//  All pos/FSM updates occur on the board_clk edge ending a cycle where tick=1 && enable=1 (call it a move tick).
//  FSM per paddle, transitions on move ticks only:
//   IDLE: dir NONE. On UP/DN go to SLOW with hold_cnt=1 and last_dir=dir; apply STEP.
//   SLOW: same dir, hold_cnt<HOLD_TICKS: apply STEP, hold_cnt++. Reaching HOLD_TICKS: next state FAST.
//   FAST: same dir: apply FAST_STEP.
//   SLOW/FAST with NONE: go to IDLE, hold_cnt=0, no move.
//   SLOW/FAST with reversed dir: go to SLOW, hold_cnt=1, apply STEP.
//  Step size is chosen from state/hold_cnt before the tick; hold_cnt saturates at HOLD_TICKS.
//  Arithmetic is POS_W+1 bits with no wrap.
//   UP: pos<POS_MIN+step gives POS_MIN, else pos-step.
//   DN: pos+step>POS_MAX gives POS_MAX, else pos+step.
//  At a clamp, a blocked move leaves pos unchanged and moved=0; FSM/hold_cnt still advance.
//  moved[i] is registered, high for exactly the cycle after a move tick in which pos[i] changed.
//  recentre[i] has highest priority, even on a move tick: pos=POS_INIT, IDLE, hold_cnt=0, moved=0. Honoured when enable=0.
//  enable=0: move ticks suppressed; pos/FSM/hold_cnt frozen; tick keeps pulsing.
//  Channels are fully independent; no cross-paddle interaction.
//  Reset mid-motion: immediate POS_INIT/IDLE; motion resumes at SLOW on the next move tick if buttons are held.
// TESTING  (sim params: TICK_DIV=4, HOLD_TICKS=3, defaults otherwise)
//  1 Assert/release reset -> pos0=pos1=240, at_min=at_max=0, moved=0; tick first high 4 cycles after release.
//  2 Hold btn_dn[0], enable=1 -> pos0 over move ticks: 242,244,246,252,258; moved[0] pulses each; pos1 stays 240.
//  3 Hold btn_up[1] from 240 -> pos1 monotonically down to exactly 10, never wraps; at_min[1]=1; moved[1] stops.
//  4 Press both buttons -> no move, FSM IDLE. Reach FAST on DN, then flip to UP -> first step -2 (slow), not -6.
//  5 Pulse recentre[0] in the same cycle as a FAST move tick -> pos0=240, no moved pulse; repeat with enable=0, same result.
//  6 Async reset mid-FAST -> pos=240 at once. enable=0 with buttons held -> pos frozen for 10 ticks, tick still pulses.

Source files
------------

// File: rtl/paddle_motion_ctrl.sv
// paddle_motion_ctrl: per-paddle position controller for the VGA/SSD game.
// Each paddle has synchronised up/down buttons and a slow/fast hold-to-accelerate
// FSM. Positions are clamped to [POS_MIN, POS_MAX]. A free-running divider
// produces the shared motion tick.
module paddle_motion_ctrl #(
   parameter int NUM_P      = 2,
   parameter int POS_W      = 10,
   parameter int POS_MIN    = 10,
   parameter int POS_MAX    = 469,
   parameter int POS_INIT   = 240,
   parameter int STEP       = 2,
   parameter int FAST_STEP  = 6,
   parameter int HOLD_TICKS = 16,
   parameter int TICK_DIV   = 2097152
) (
   input  logic                   board_clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_P-1:0]       btn_up,
   input  logic [NUM_P-1:0]       btn_dn,
   input  logic [NUM_P-1:0]       recentre,
   output logic [NUM_P*POS_W-1:0] pos,
   output logic [NUM_P-1:0]       at_min,
   output logic [NUM_P-1:0]       at_max,
   output logic [NUM_P-1:0]       moved,
   output logic                   tick
);

   typedef enum logic [1:0] {ST_IDLE, ST_SLOW, ST_FAST} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
   localparam logic [POS_W-1:0]  MIN_P     = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]  MAX_P     = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  INIT_P    = POS_W'(POS_INIT);
   // Arithmetic is one bit wider than a position so sums and differences never wrap.
   localparam logic [POS_W:0]    MIN_X     = (POS_W+1)'(POS_MIN);
   localparam logic [POS_W:0]    MAX_X     = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W:0]    STEP_X    = (POS_W+1)'(STEP);
   localparam logic [POS_W:0]    FAST_X    = (POS_W+1)'(FAST_STEP);

   // Two-stage synchronisers for the raw asynchronous buttons.
   logic [NUM_P-1:0]  up_meta_q, up_meta_d, up_sync_q, up_sync_d;
   logic [NUM_P-1:0]  dn_meta_q, dn_meta_d, dn_sync_q, dn_sync_d;

   logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic              tick_q, tick_d;
   logic              move_tick;

   logic [POS_W-1:0]  pos_q      [NUM_P];
   logic [POS_W-1:0]  pos_d      [NUM_P];
   state_t            state_q    [NUM_P];
   state_t            state_d    [NUM_P];
   logic [HOLD_W-1:0] hold_q     [NUM_P];
   logic [HOLD_W-1:0] hold_d     [NUM_P];
   dir_t              last_dir_q [NUM_P];
   dir_t              last_dir_d [NUM_P];
   logic [NUM_P-1:0]  moved_q, moved_d;

   // Motion only happens on the edge that ends a cycle with tick high and enable set.
   assign move_tick = tick_q & enable;

   // Next-state logic: synchronisers, tick divider and per-paddle motion FSM.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a value unassigned (no latches).
      up_meta_d  = btn_up;
      up_sync_d  = up_meta_q;
      dn_meta_d  = btn_dn;
      dn_sync_d  = dn_meta_q;
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      tick_d     = (tick_cnt_q == TICK_LAST);
      moved_d    = '0;

      for (int i = 0; i < NUM_P; i++) begin
         dir_t           dir;
         logic [POS_W:0] pos_x;
         logic [POS_W:0] step_x;
         logic [POS_W:0] new_x;
         logic [HOLD_W-1:0] hold_inc;

         pos_d[i]      = pos_q[i];
         state_d[i]    = state_q[i];
         hold_d[i]     = hold_q[i];
         last_dir_d[i] = last_dir_q[i];

         if (up_sync_q[i] && !dn_sync_q[i])      dir = DIR_UP;
         else if (dn_sync_q[i] && !up_sync_q[i]) dir = DIR_DN;
         else                                    dir = DIR_NONE;

         // Fast step only when already FAST and still pushing the same way.
         step_x = (state_q[i] == ST_FAST && dir == last_dir_q[i]) ? FAST_X : STEP_X;
         pos_x  = {1'b0, pos_q[i]};

         case (dir)
            DIR_UP:  new_x = (pos_x < MIN_X + step_x) ? MIN_X : pos_x - step_x;
            DIR_DN:  new_x = (pos_x + step_x > MAX_X) ? MAX_X : pos_x + step_x;
            default: new_x = pos_x;
         endcase

         hold_inc = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;

         if (move_tick) begin
            if (dir == DIR_NONE) begin
               state_d[i] = ST_IDLE;
               hold_d[i]  = '0;
            end else if (state_q[i] == ST_IDLE || dir != last_dir_q[i]) begin
               state_d[i]    = ST_SLOW;
               hold_d[i]     = HOLD_W'(1);
               last_dir_d[i] = dir;
            end else if (state_q[i] == ST_SLOW) begin
               hold_d[i]  = hold_inc;
               state_d[i] = (hold_inc == HOLD_MAX) ? ST_FAST : ST_SLOW;
            end
            pos_d[i]   = new_x[POS_W-1:0];
            moved_d[i] = (new_x != pos_x);
         end

         // Recentre overrides everything, including a simultaneous move tick.
         if (recentre[i]) begin
            pos_d[i]   = INIT_P;
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
            moved_d[i] = 1'b0;
         end
      end
   end

   // State registers for all paddles, synchronisers and the tick divider.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         up_meta_q  <= '0;
         up_sync_q  <= '0;
         dn_meta_q  <= '0;
         dn_sync_q  <= '0;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
         moved_q    <= '0;
         // NOTE: the per-paddle arrays are discrete flops rather than a RAM, so resetting every entry is intended.
         for (int i = 0; i < NUM_P; i++) begin
            pos_q[i]      <= INIT_P;
            state_q[i]    <= ST_IDLE;
            hold_q[i]     <= '0;
            last_dir_q[i] <= DIR_NONE;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         up_meta_q  <= up_meta_d;
         up_sync_q  <= up_sync_d;
         dn_meta_q  <= dn_meta_d;
         dn_sync_q  <= dn_sync_d;
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
         moved_q    <= moved_d;
         pos_q      <= pos_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         last_dir_q <= last_dir_d;
      end
   end

   // Pack positions and decode the clamp flags from the registered positions.
   for (genvar g = 0; g < NUM_P; g++) begin : g_out
      assign pos[g*POS_W +: POS_W] = pos_q[g];
      assign at_min[g]             = (pos_q[g] == MIN_P);
      assign at_max[g]             = (pos_q[g] == MAX_P);
   end

   assign moved = moved_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Testbench for paddle_motion_ctrl with TICK_DIV=4, HOLD_TICKS=3.
// Stimulus pushes the expected post-tick state into a scoreboard queue; the
// monitor pops and compares in the cycle after every tick pulse.
module tb_paddle_motion_ctrl;

   logic        board_clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  btn_up;
   logic [1:0]  btn_dn;
   logic [1:0]  recentre;
   logic [19:0] pos;
   logic [1:0]  at_min;
   logic [1:0]  at_max;
   logic [1:0]  moved;
   logic        tick;

   always #5 board_clk = ~board_clk;

   paddle_motion_ctrl #(
      .NUM_P(2), .POS_W(10), .POS_MIN(10), .POS_MAX(469), .POS_INIT(240),
      .STEP(2), .FAST_STEP(6), .HOLD_TICKS(3), .TICK_DIV(4)
   ) dut (
      .board_clk(board_clk),
      .reset    (reset),
      .enable   (enable),
      .btn_up   (btn_up),
      .btn_dn   (btn_dn),
      .recentre (recentre),
      .pos      (pos),
      .at_min   (at_min),
      .at_max   (at_max),
      .moved    (moved),
      .tick     (tick)
   );

   typedef struct {
      string      name;
      int         p0;
      int         p1;
      logic [1:0] mv;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   logic mon_was_tick;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_exp(input string name, input int p0, input int p1, input logic [1:0] mv);
      exp_t e;
      e.name = name;
      e.p0   = p0;
      e.p1   = p1;
      e.mv   = mv;
      sb_q.push_back(e);
      n_push++;
   endfunction

   // Advance to the next falling edge where tick is high; n = edges waited.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge board_clk);
         n++;
      end while (tick !== 1'b1 && n < 20);
      if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
   endtask

   task automatic tick_exp(input string name, input int p0, input int p1, input logic [1:0] mv);
      int n;
      wait_tick(n);
      push_exp(name, p0, p1, mv);
   endtask

   // Monitor: the cycle after a tick pulse is when new positions are presented.
   initial begin
      exp_t e;
      mon_was_tick = 1'b0;
      forever begin
         @(negedge board_clk);
         if (mon_was_tick && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_pop++;
            check({e.name, "_pos0"},   32'(pos[9:0]),   e.p0);
            check({e.name, "_pos1"},   32'(pos[19:10]), e.p1);
            check({e.name, "_moved"},  32'(moved),      32'(e.mv));
            check({e.name, "_at_min"}, 32'(at_min),     32'({e.p1 == 10, e.p0 == 10}));
            check({e.name, "_at_max"}, 32'(at_max),     32'({e.p1 == 469, e.p0 == 469}));
         end
         mon_was_tick = tick;
      end
   end

   // Stimulus.
   initial begin
      int n;
      int p;
      reset    = 1'b1;
      enable   = 1'b0;
      btn_up   = '0;
      btn_dn   = '0;
      recentre = '0;
      repeat (3) @(negedge board_clk);
      check("rst_pos",    32'(pos), 32'({10'd240, 10'd240}));
      check("rst_minmax", 32'({at_min, at_max}), 32'd0);
      check("rst_moved",  32'(moved), 32'd0);
      check("rst_tick",   32'(tick), 32'd0);
      reset = 1'b0;

      // First tick four cycles after release; nothing held, so no motion.
      wait_tick(n);
      check("first_tick_delay", n, 32'd4);
      push_exp("idle", 240, 240, 2'b00);
      enable    = 1'b1;
      btn_dn[0] = 1'b1;

      // Paddle 0 down: slow, slow, slow, then fast.
      tick_exp("dn0_1", 242, 240, 2'b01);
      tick_exp("dn0_2", 244, 240, 2'b01);
      tick_exp("dn0_3", 246, 240, 2'b01);
      tick_exp("dn0_4", 252, 240, 2'b01);
      tick_exp("dn0_5", 258, 240, 2'b01);
      btn_dn[0] = 1'b0;
      btn_up[1] = 1'b1;

      // Paddle 1 up all the way to the minimum clamp.
      tick_exp("up1_1", 258, 238, 2'b10);
      tick_exp("up1_2", 258, 236, 2'b10);
      tick_exp("up1_3", 258, 234, 2'b10);
      p = 234;
      while (p - 6 >= 10) begin
         p = p - 6;
         tick_exp("up1_fast", 258, p, 2'b10);
      end
      tick_exp("up1_clamp", 258, 10, 2'b10);
      tick_exp("up1_block_a", 258, 10, 2'b00);
      tick_exp("up1_block_b", 258, 10, 2'b00);
      btn_up[1] = 1'b0;
      btn_up[0] = 1'b1;
      btn_dn[0] = 1'b1;

      // Both buttons on paddle 0: no motion.
      tick_exp("both_a", 258, 10, 2'b00);
      tick_exp("both_b", 258, 10, 2'b00);
      btn_up[0] = 1'b0;

      // Reach FAST going down, then reverse: first step back is slow.
      tick_exp("dn_fast_1", 260, 10, 2'b01);
      tick_exp("dn_fast_2", 262, 10, 2'b01);
      tick_exp("dn_fast_3", 264, 10, 2'b01);
      tick_exp("dn_fast_4", 270, 10, 2'b01);
      btn_dn[0] = 1'b0;
      btn_up[0] = 1'b1;
      tick_exp("flip_1", 268, 10, 2'b01);
      tick_exp("flip_2", 266, 10, 2'b01);
      tick_exp("flip_3", 264, 10, 2'b01);
      tick_exp("flip_4", 258, 10, 2'b01);

      // Recentre on the same edge as a FAST move tick.
      tick_exp("recentre_fast", 240, 10, 2'b00);
      recentre[0] = 1'b1;
      @(negedge board_clk);
      recentre[0] = 1'b0;
      tick_exp("after_rc_1", 238, 10, 2'b01);
      tick_exp("after_rc_2", 236, 10, 2'b01);
      tick_exp("after_rc_3", 234, 10, 2'b01);
      tick_exp("after_rc_4", 228, 10, 2'b01);

      // Recentre with enable low.
      tick_exp("recentre_dis", 240, 10, 2'b00);
      enable      = 1'b0;
      recentre[0] = 1'b1;
      @(negedge board_clk);
      recentre[0] = 1'b0;
      tick_exp("frozen_rc", 240, 10, 2'b00);
      @(negedge board_clk);
      enable = 1'b1;

      // Back into FAST, then an asynchronous reset mid-cycle.
      tick_exp("pre_rst_1", 238, 10, 2'b01);
      tick_exp("pre_rst_2", 236, 10, 2'b01);
      tick_exp("pre_rst_3", 234, 10, 2'b01);
      tick_exp("pre_rst_4", 228, 10, 2'b01);
      @(negedge board_clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_pos",    32'(pos), 32'({10'd240, 10'd240}));
      check("async_rst_moved",  32'(moved), 32'd0);
      check("async_rst_tick",   32'(tick), 32'd0);
      check("async_rst_at_min", 32'(at_min), 32'd0);
      @(negedge board_clk);
      reset = 1'b0;
      wait_tick(n);
      check("restart_tick_delay", n, 32'd4);
      push_exp("resume_slow", 238, 240, 2'b01);
      @(negedge board_clk);
      enable = 1'b0;

      // Buttons held with enable low: frozen, tick still every 4 cycles.
      for (int i = 0; i < 10; i++) begin
         wait_tick(n);
         if (i > 0) check("tick_period", n, 32'd4);
         push_exp("frozen_en0", 238, 240, 2'b00);
      end
      btn_up[0] = 1'b0;
      btn_dn[0] = 1'b1;
      @(negedge board_clk);
      enable = 1'b1;

      // Reverse to down and run into the maximum clamp.
      tick_exp("max_1", 240, 240, 2'b01);
      tick_exp("max_2", 242, 240, 2'b01);
      tick_exp("max_3", 244, 240, 2'b01);
      p = 244;
      while (p + 6 <= 469) begin
         p = p + 6;
         tick_exp("max_fast", p, 240, 2'b01);
      end
      tick_exp("max_clamp", 469, 240, 2'b01);
      tick_exp("max_block", 469, 240, 2'b00);

      @(negedge board_clk);
      @(negedge board_clk);
      check("sb_drained", n_pop, n_push);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
